// File: rtl/p_out_skid.sv
// -----------------------------------------------------------------------------
// p_out_skid
//   Output skid buffer for a P result bus. When PIPE_ON=1 it is a registered
//   two-entry buffer: a main register that drives m_data and a skid register
//   that absorbs one result when downstream stalls. s_ready depends only on
//   the buffer state, so no combinational path runs from m_ready to s_ready.
//   When PIPE_ON=0 the block is a plain wire-through with ce gating.
//
// Parameters
//   WIDTH     data path width in bits
//   PIPE_ON   1 = registered skid buffer, 0 = combinational pass-through
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   ce         clock enable; 0 freezes all state and blocks both handshakes
//   s_valid    upstream result valid
//   s_ready    block can accept upstream data
//   s_data     upstream result
//   m_valid    m_data holds a valid result
//   m_ready    downstream accepts m_data
//   m_data     result to downstream
//   occupancy  number of stored entries (0..2)
// -----------------------------------------------------------------------------
module p_out_skid #(
  parameter int WIDTH   = 48,
  parameter bit PIPE_ON = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy
);

  generate
    if (PIPE_ON) begin : g_pipe
      // State encoding doubles as the occupancy count.
      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
      } state_t;

      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] r_skid;
      logic             w_in;
      logic             w_out;
      logic             w_load_main;
      logic             w_main_from_skid;
      logic             w_load_skid;

      // rst gates s_ready so nothing is offered while reset is held.
      assign s_ready   = ce & ~rst & (r_state != ST_FULL);
      assign m_valid   = ce & (r_state != ST_EMPTY);
      assign m_data    = r_main;
      assign occupancy = r_state;

      assign w_in  = s_valid & s_ready;
      assign w_out = m_valid & m_ready;

      always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
          ST_EMPTY: begin
            if (w_in) begin
              w_load_main = 1'b1;
              w_state_nxt = ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (w_in && w_out) begin
              w_load_main = 1'b1;
            end else if (w_in) begin
              // Downstream stalled: park the new result behind main.
              w_load_skid = 1'b1;
              w_state_nxt = ST_FULL;
            end else if (w_out) begin
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (w_out) begin
              w_main_from_skid = 1'b1;
              w_state_nxt      = ST_BUSY;
            end
          end
          default: begin
            w_state_nxt = ST_EMPTY;
          end
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= ST_EMPTY;
          r_main  <= '0;
          r_skid  <= '0;
        end else if (ce) begin
          r_state <= w_state_nxt;
          if (w_load_main) begin
            r_main <= s_data;
          end else if (w_main_from_skid) begin
            r_main <= r_skid;
          end
          if (w_load_skid) begin
            r_skid <= s_data;
          end
        end
      end
    end else begin : g_pass
      logic w_unused;

      // Clock and reset have no role in pass-through mode.
      assign w_unused  = clk ^ rst;
      assign m_data    = s_data;
      assign m_valid   = s_valid & ce;
      assign s_ready   = m_ready & ce;
      assign occupancy = 2'd0;
    end
  endgenerate

endmodule

// File: tb/tb_p_out_skid.sv
// -----------------------------------------------------------------------------
// tb_p_out_skid
//   Directed and randomized bench for p_out_skid with PIPE_ON=1, WIDTH=48.
// -----------------------------------------------------------------------------
module tb_p_out_skid;

  localparam int W = 48;

  logic         clk;
  logic         rst;
  logic         ce;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   occupancy;

  int errors = 0;
  int checks = 0;

  p_out_skid #(.WIDTH(W), .PIPE_ON(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] q[$];
  logic         prev_stall;
  logic [W-1:0] prev_data;
  logic         in_f;
  logic         out_f;
  logic [W-1:0] cnt;

  initial begin
    rst = 1'b1; ce = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;

    // Reset state
    #3;
    chk("rst_s_ready", {47'd0, s_ready}, 48'd0);
    chk("rst_m_valid", {47'd0, m_valid}, 48'd0);
    chk("rst_m_data", m_data, 48'd0);
    chk("rst_occ", {46'd0, occupancy}, 48'd0);
    tick();
    tick();
    chk("rst_hold_s_ready", {47'd0, s_ready}, 48'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", {47'd0, s_ready}, 48'd1);

    // Single transfer, one cycle latency
    s_data = 48'h0000_0000_0AAA; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("single_m_valid", {47'd0, m_valid}, 48'd1);
    chk("single_m_data", m_data, 48'h0AAA);
    chk("single_occ", {46'd0, occupancy}, 48'd1);
    tick();
    chk("single_drain", {47'd0, m_valid}, 48'd0);

    // Full-rate stream 1..5
    for (int i = 1; i <= 5; i++) begin
      s_data = W'(i); s_valid = 1'b1;
      #1;
      chk("stream_s_ready", {47'd0, s_ready}, 48'd1);
      tick();
      chk("stream_m_data", m_data, W'(i));
      chk("stream_m_valid", {47'd0, m_valid}, 48'd1);
      chk("stream_occ", {46'd0, occupancy}, 48'd1);
    end
    s_valid = 1'b0;
    tick();
    chk("stream_end", {47'd0, m_valid}, 48'd0);

    // Stall fills the skid register
    m_ready = 1'b0;
    s_data = 48'd1; s_valid = 1'b1; tick();
    s_data = 48'd2; tick();
    s_data = 48'd3;
    chk("stall_occ", {46'd0, occupancy}, 48'd2);
    chk("stall_s_ready", {47'd0, s_ready}, 48'd0);
    chk("stall_m_data", m_data, 48'd1);
    tick();
    chk("stall_hold_occ", {46'd0, occupancy}, 48'd2);
    chk("stall_hold_data", m_data, 48'd1);
    m_ready = 1'b1;
    #1;
    chk("drain_out1", m_data, 48'd1);
    tick();
    chk("drain_out2", m_data, 48'd2);
    chk("drain_occ", {46'd0, occupancy}, 48'd1);
    chk("drain_s_ready", {47'd0, s_ready}, 48'd1);
    tick();
    s_valid = 1'b0;
    chk("drain_out3", m_data, 48'd3);
    chk("drain_out3_valid", {47'd0, m_valid}, 48'd1);
    tick();
    chk("drain_empty", {47'd0, m_valid}, 48'd0);

    // ce freezes a full buffer
    m_ready = 1'b0;
    s_data = 48'd7; s_valid = 1'b1; tick();
    s_data = 48'd8; tick();
    s_valid = 1'b0;
    ce = 1'b0; m_ready = 1'b1;
    #1;
    chk("ce_m_valid", {47'd0, m_valid}, 48'd0);
    chk("ce_s_ready", {47'd0, s_ready}, 48'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ce_occ", {46'd0, occupancy}, 48'd2);
      chk("ce_m_valid_hold", {47'd0, m_valid}, 48'd0);
    end
    ce = 1'b1;
    #1;
    chk("ce_out7_valid", {47'd0, m_valid}, 48'd1);
    chk("ce_out7", m_data, 48'd7);
    tick();
    chk("ce_out8", m_data, 48'd8);
    chk("ce_out8_occ", {46'd0, occupancy}, 48'd1);
    tick();
    chk("ce_empty", {47'd0, m_valid}, 48'd0);

    // Asynchronous reset while full
    m_ready = 1'b0;
    s_data = 48'd5; s_valid = 1'b1; tick();
    s_data = 48'd6; tick();
    s_valid = 1'b0;
    chk("pre_arst_occ", {46'd0, occupancy}, 48'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", {47'd0, m_valid}, 48'd0);
    chk("arst_m_data", m_data, 48'd0);
    chk("arst_occ", {46'd0, occupancy}, 48'd0);
    chk("arst_s_ready", {47'd0, s_ready}, 48'd0);
    tick();
    rst = 1'b0;
    s_data = 48'd9; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("arst_new9", m_data, 48'd9);
    chk("arst_new9_occ", {46'd0, occupancy}, 48'd1);
    m_ready = 1'b1;
    tick();
    chk("arst_after9", {47'd0, m_valid}, 48'd0);

    // Random traffic against a queue scoreboard
    q.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    cnt        = 48'h1000;
    for (int c = 0; c < 10000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = cnt;
      #1;
      if (prev_stall) chk("rnd_stable", m_data, prev_data);
      chk("rnd_m_valid", {47'd0, m_valid}, {47'd0, (q.size() != 0)});
      chk("rnd_occ", {46'd0, occupancy}, W'(q.size()));
      in_f  = s_valid & s_ready;
      out_f = m_valid & m_ready;
      if (out_f) begin
        if (q.size() != 0) begin
          chk("rnd_order", m_data, q[0]);
          void'(q.pop_front());
        end
      end
      if (in_f) begin
        q.push_back(cnt);
        cnt = cnt + 48'd1;
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
